wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter XLEN, default 32, sets data width of every register and data port.
REQ-002 Parameter NREG, default 32, sets architectural register count; address width is 5 bits.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous and active-low.
REQ-005 WB_i  input  1  writeback enable from MEM/WB stage.
REQ-006 WBSrc_i  input  1  writeback source select: 1 = MemRdata_i, 0 = ALUres_i.
REQ-007 MemRdata_i  input  XLEN  load data from MEM/WB.
REQ-008 ALUres_i  input  XLEN  ALU result from MEM/WB.
REQ-009 rd_addr_i  input  5  destination register from MEM/WB.
REQ-010 rs1_addr_i, rs2_addr_i  input  5 each  decode-stage read addresses.
REQ-011 rs1_data_o, rs2_data_o  output  XLEN each  read data.
REQ-012 wb_data_o  output  XLEN  selected writeback value, combinational.
REQ-013 wb_cnt_o  output  32  count of committed register writes.

Function
REQ-014 wb_data_o SHALL equal MemRdata_i when WBSrc_i=1, else ALUres_i, every cycle regardless of WB_i.
REQ-015 A write commits on the rising clk_i edge when WB_i=1 and rd_addr_i!=0: reg[rd_addr_i] <= wb_data_o.
REQ-016 Writes with rd_addr_i=0 SHALL be discarded; reg[0] reads 0 at all times.
REQ-017 WB_i=0 SHALL leave every register unchanged.
REQ-018 Read ports SHALL be combinational, zero-latency, independent; both may address the same register.
REQ-019 Address 0 on either read port SHALL return 0, including any same-cycle write to 0.
REQ-020 wb_cnt_o SHALL increment by 1 on each committed write (REQ-015), not on discarded writes; wraps 0xFFFFFFFF -> 0.
REQ-021 Same-cycle read and write to the same nonzero register: behaviour per REQ-027/028.
REQ-022 Write and read of different registers in the same cycle SHALL not interfere.

Reset
REQ-023 rst_i=0 SHALL immediately, without clock, clear all NREG registers and wb_cnt_o to 0.
REQ-024 While rst_i=0, rs1_data_o/rs2_data_o SHALL read 0 and no write SHALL commit.
REQ-025 A write presented in the cycle rst_i deasserts SHALL commit only on the first rising edge with rst_i=1.

Configuration
REQ-026 Macro WB_BYPASS_EN selects internal write-through forwarding.
REQ-027 With WB_BYPASS_EN defined: if WB_i=1, rd_addr_i!=0 and rsX_addr_i==rd_addr_i, rsX_data_o SHALL equal wb_data_o in the same cycle.
REQ-028 Without WB_BYPASS_EN: rsX_data_o SHALL return the stored (old) value; new value visible from the cycle after the commit edge.

Verification
REQ-029 Reset: drive rst_i=0 mid-run after writes -> all reads 0, wb_cnt_o=0 without clock edge.
REQ-030 WB_i=1, WBSrc_i=0, ALUres_i=0x12345678, rd=5; next cycle rs1=5 -> 0x12345678, wb_cnt_o=1.
REQ-031 WB_i=1, WBSrc_i=1, MemRdata_i=0xDEADBEEF, rd=0 -> rs1=0 reads 0, wb_cnt_o unchanged.
REQ-032 WB_i=1, rd=7, ALUres_i=0xA5A5A5A5, rs1=rs2=7 same cycle -> 0xA5A5A5A5 with WB_BYPASS_EN, old value (0) without.
REQ-033 WB_i=0 with rd=3, data 0xFFFFFFFF -> reg 3 unchanged, wb_cnt_o unchanged.
REQ-034 Preload wb_cnt_o to 0xFFFFFFFF via 2^32-1 writes (or force) then one write -> wb_cnt_o=0.

Source files
------------

// File: rtl/wb_regfile.sv
// wb_regfile -- architectural register file with writeback mux and commit counter.
//
// Purpose:
//   Holds NREG registers of XLEN bits. Register 0 is hard-wired to zero.
//   The writeback value is selected from load data or ALU result. When WB_i is
//   high and the destination is nonzero, that value is written on the rising
//   clock edge, and wb_cnt_o counts the write.
//
// Ports:
//   clk_i                  rising-edge clock
//   rst_i                  asynchronous active-low reset; clears all registers and
//                          the counter; reads return 0 while it is asserted
//   WB_i                   writeback enable from MEM/WB
//   WBSrc_i                writeback source: 1 = MemRdata_i, 0 = ALUres_i
//   MemRdata_i, ALUres_i   candidate writeback values
//   rd_addr_i              destination register
//   rs1_addr_i, rs2_addr_i combinational read addresses
//   rs1_data_o, rs2_data_o read data
//   wb_data_o              selected writeback value, valid every cycle
//   wb_cnt_o               committed-write count, wraps at 2^32
//
// Configuration:
//   WB_BYPASS_EN  When defined, a read of the register being written in the
//                 same cycle returns the new value (write-through). When
//                 undefined, the read returns the stored old value.
module wb_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            WB_i,
  input  logic            WBSrc_i,
  input  logic [XLEN-1:0] MemRdata_i,
  input  logic [XLEN-1:0] ALUres_i,
  input  logic [4:0]      rd_addr_i,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic [31:0]     wb_cnt_o
);

  localparam logic [5:0] NREG_L = 6'(NREG);

  logic [XLEN-1:0] regs [NREG];
  logic [31:0]     wb_cnt;
  logic            wr_commit;

  assign wb_data_o = WBSrc_i ? MemRdata_i : ALUres_i;
  assign wb_cnt_o  = wb_cnt;

  // Gated by rst_i so that no write commits, and nothing is forwarded, while
  // the register file is held in reset. Addresses at or above NREG are dropped.
  assign wr_commit = rst_i && WB_i && (rd_addr_i != 5'd0) &&
                     ({1'b0, rd_addr_i} < NREG_L);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      wb_cnt <= '0;
    end else if (wr_commit) begin
      regs[rd_addr_i] <= wb_data_o;
      wb_cnt          <= wb_cnt + 32'd1;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [4:0] addr);
    logic [XLEN-1:0] val;
    val = '0;
    if (rst_i && (addr != 5'd0) && ({1'b0, addr} < NREG_L)) begin
      val = regs[addr];
`ifdef WB_BYPASS_EN
      if (wr_commit && (addr == rd_addr_i)) begin
        val = wb_data_o;
      end
`endif
    end
    return val;
  endfunction

  always_comb begin
    rs1_data_o = read_port(rs1_addr_i);
    rs2_data_o = read_port(rs2_addr_i);
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile -- bench for wb_regfile.
//
// An array-based model of the register file tracks committed writes. A monitor
// compares every DUT output against that model on each falling clock edge.
// Directed steps also check hand-computed literal values.
module tb_wb_regfile;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        WB_i;
  logic        WBSrc_i;
  logic [31:0] MemRdata_i;
  logic [31:0] ALUres_i;
  logic [4:0]  rd_addr_i;
  logic [4:0]  rs1_addr_i;
  logic [4:0]  rs2_addr_i;
  logic [31:0] rs1_data_o;
  logic [31:0] rs2_data_o;
  logic [31:0] wb_data_o;
  logic [31:0] wb_cnt_o;

  int n_asserts = 0;
  int n_fail    = 0;
  bit mon_en    = 1'b0;

  logic [31:0] mreg [32];
  logic [31:0] mcnt;

  wb_regfile #(.XLEN(32), .NREG(32)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .WB_i       (WB_i),
    .WBSrc_i    (WBSrc_i),
    .MemRdata_i (MemRdata_i),
    .ALUres_i   (ALUres_i),
    .rd_addr_i  (rd_addr_i),
    .rs1_addr_i (rs1_addr_i),
    .rs2_addr_i (rs2_addr_i),
    .rs1_data_o (rs1_data_o),
    .rs2_data_o (rs2_data_o),
    .wb_data_o  (wb_data_o),
    .wb_cnt_o   (wb_cnt_o)
  );

  always #5 clk_i = ~clk_i;

`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  function automatic logic [31:0] model_wb();
    return WBSrc_i ? MemRdata_i : ALUres_i;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (!rst_i || a == 5'd0) return 32'd0;
    if (BYPASS && WB_i && rd_addr_i == a) return model_wb();
    return mreg[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: a write lands on a rising edge only when out of reset.
  always @(posedge clk_i) begin
    if (rst_i === 1'b1 && WB_i && rd_addr_i != 5'd0) begin
      mreg[rd_addr_i] = model_wb();
      mcnt = mcnt + 32'd1;
    end
  end

  always @(negedge rst_i) begin
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    mcnt = 32'd0;
  end

  always @(negedge clk_i) begin
    if (mon_en) begin
      chk("mon_wb_data", wb_data_o, model_wb());
      chk("mon_rs1", rs1_data_o, model_read(rs1_addr_i));
      chk("mon_rs2", rs2_data_o, model_read(rs2_addr_i));
      chk("mon_cnt", wb_cnt_o, rst_i ? mcnt : 32'd0);
    end
  end

  // Drive at posedge+1, then return at negedge+1 so combinational
  // values can be checked before the next commit edge.
  task automatic apply(input logic wb, input logic src, input logic [31:0] mem,
                       input logic [31:0] alu, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    WB_i = wb; WBSrc_i = src; MemRdata_i = mem; ALUres_i = alu;
    rd_addr_i = rd; rs1_addr_i = rs1; rs2_addr_i = rs2;
    @(negedge clk_i); #1;
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    mcnt = 32'd0;
    rst_i = 1'b0;
    // Write presented while in reset must not commit.
    WB_i = 1'b1; WBSrc_i = 1'b0; MemRdata_i = 32'd0; ALUres_i = 32'h11;
    rd_addr_i = 5'd1; rs1_addr_i = 5'd1; rs2_addr_i = 5'd1;
    mon_en = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i); #1;
    chk("reset_cnt", wb_cnt_o, 32'd0);
    chk("reset_rs1", rs1_data_o, 32'd0);
    chk("reset_wb_data", wb_data_o, 32'h11);

    // Deassert between edges; the pending write commits on the next rising edge.
    rst_i = 1'b1;
    #1;
    chk("deassert_pre_cnt", wb_cnt_o, 32'd0);
    chk("deassert_pre_rs2", rs2_data_o, BYPASS ? 32'h11 : 32'd0);
    tick();
    apply(1'b0, 1'b0, 32'd0, 32'd0, 5'd1, 5'd1, 5'd0);
    chk("deassert_commit_rs1", rs1_data_o, 32'h11);
    chk("deassert_commit_cnt", wb_cnt_o, 32'd1);
    tick();

    // ALU writeback to r5.
    apply(1'b1, 1'b0, 32'h0, 32'h12345678, 5'd5, 5'd5, 5'd0);
    chk("alu_wr_same_cycle", rs1_data_o, BYPASS ? 32'h12345678 : 32'd0);
    tick();
    apply(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0);
    chk("alu_wr_rs1", rs1_data_o, 32'h12345678);
    chk("alu_wr_cnt", wb_cnt_o, 32'd2);
    tick();

    // Memory writeback to r0 is discarded.
    apply(1'b1, 1'b1, 32'hDEADBEEF, 32'h0, 5'd0, 5'd0, 5'd0);
    chk("r0_wb_data", wb_data_o, 32'hDEADBEEF);
    chk("r0_same_cycle", rs1_data_o, 32'd0);
    tick();
    apply(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    chk("r0_after", rs1_data_o, 32'd0);
    chk("r0_cnt", wb_cnt_o, 32'd2);
    tick();

    // WB_i low: no write.
    apply(1'b0, 1'b0, 32'h0, 32'hFFFFFFFF, 5'd3, 5'd3, 5'd3);
    tick();
    apply(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd3);
    chk("nowb_r3", rs1_data_o, 32'd0);
    chk("nowb_cnt", wb_cnt_o, 32'd2);
    tick();

    // Same-cycle read/write of r7 on both ports.
    apply(1'b1, 1'b0, 32'h0, 32'hA5A5A5A5, 5'd7, 5'd7, 5'd7);
    chk("byp_rs1", rs1_data_o, BYPASS ? 32'hA5A5A5A5 : 32'd0);
    chk("byp_rs2", rs2_data_o, BYPASS ? 32'hA5A5A5A5 : 32'd0);
    tick();
    apply(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7);
    chk("r7_rs1", rs1_data_o, 32'hA5A5A5A5);
    chk("r7_rs2", rs2_data_o, 32'hA5A5A5A5);
    chk("r7_cnt", wb_cnt_o, 32'd3);
    tick();

    // Write r9 while reading other registers.
    apply(1'b1, 1'b0, 32'h0, 32'h99, 5'd9, 5'd5, 5'd1);
    chk("indep_rs1", rs1_data_o, 32'h12345678);
    chk("indep_rs2", rs2_data_o, 32'h11);
    tick();

    // Overwrite r5 from memory.
    apply(1'b1, 1'b1, 32'hCAFEF00D, 32'h0, 5'd5, 5'd5, 5'd9);
    chk("ovw_rs1", rs1_data_o, BYPASS ? 32'hCAFEF00D : 32'h12345678);
    chk("ovw_rs2", rs2_data_o, 32'h99);
    tick();
    apply(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd9);
    chk("ovw_after", rs1_data_o, 32'hCAFEF00D);
    chk("ovw_cnt", wb_cnt_o, 32'd5);
    tick();

    // Mixed traffic, checked by the monitor against the model.
    for (int i = 0; i < 200; i++) begin
      logic [4:0] rd;
      rd = 5'($urandom_range(0, 31));
      apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom, rd,
            ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31)));
      tick();
    end

    // Counter wrap: preload to all ones, then one committed write.
    apply(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    force dut.wb_cnt = 32'hFFFFFFFF;
    mcnt = 32'hFFFFFFFF;
    #1;
    release dut.wb_cnt;
    tick();
    apply(1'b1, 1'b0, 32'h0, 32'h2222, 5'd2, 5'd2, 5'd0);
    chk("wrap_pre", wb_cnt_o, 32'hFFFFFFFF);
    tick();
    chk("wrap_post", wb_cnt_o, 32'd0);

    // Asynchronous reset mid-cycle with a write pending on a read address.
    apply(1'b1, 1'b0, 32'h0, 32'h77, 5'd7, 5'd2, 5'd7);
    #1;
    rst_i = 1'b0;
    #1;
    chk("async_rst_rs1", rs1_data_o, 32'd0);
    chk("async_rst_rs2", rs2_data_o, 32'd0);
    chk("async_rst_cnt", wb_cnt_o, 32'd0);
    tick();
    tick();
    chk("in_rst_cnt", wb_cnt_o, 32'd0);
    chk("in_rst_rs2", rs2_data_o, 32'd0);
    apply(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd2);
    rst_i = 1'b1;
    tick();
    apply(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd2);
    chk("post_rst_r7", rs1_data_o, 32'd0);
    chk("post_rst_r2", rs2_data_o, 32'd0);
    chk("post_rst_cnt", wb_cnt_o, 32'd0);
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
